// File: rtl/hazard_if.sv
// Handshake bundle between the RISC-V datapath and hazard_ctrl.
// The datapath side uses modport master, the hazard controller uses modport slave.
interface hazard_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic              PCSrcE, ResultSrcEb0, RegWriteM, RegWriteW;
   logic              MdStartE, DmemReqM, DmemReadyM;
   logic [1:0]        ForwardAE, ForwardBE;
   logic              StallF, StallD, StallE, StallM;
   logic              FlushD, FlushE, FlushM, FlushW;
   logic              MdBusy, MemErr;
   logic [CNT_W-1:0]  PerfStallCnt, PerfFlushCnt;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output PCSrcE, ResultSrcEb0, RegWriteM, RegWriteW,
      output MdStartE, DmemReqM, DmemReadyM,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushM, FlushW, MdBusy, MemErr,
      input  PerfStallCnt, PerfFlushCnt
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  PCSrcE, ResultSrcEb0, RegWriteM, RegWriteW,
      input  MdStartE, DmemReqM, DmemReadyM,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushM, FlushW, MdBusy, MemErr,
      output PerfStallCnt, PerfFlushCnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline: forwarding, load-use, branch flush,
// MUL/DIV freeze and memory wait/timeout. Define HAZARD_PERF_CNT_EN to build the perf counters.
module hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int MD_LATENCY  = 4,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input logic   clk,
   input logic   rst_n,
   hazard_if.slave hz
);
   localparam int MD_CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
   localparam int WT_CW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] MD_BUSY = 1'b1;

   logic [0:0]       state;
   logic [MD_CW-1:0] md_cnt;
   logic [WT_CW-1:0] wait_cnt;
   logic             mem_err;
   logic             mem_wait, md_start, md_stall, lw_stall, br_fire;

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
      if (rs == '0)                            return 2'b00;
      else if (hz.RegWriteM && rs == hz.RdM)   return 2'b10;
      else if (hz.RegWriteW && rs == hz.RdW)   return 2'b01;
      else                                     return 2'b00;
   endfunction

   assign mem_wait = hz.DmemReqM & ~hz.DmemReadyM;
   assign md_start = (MD_LATENCY > 1) && hz.MdStartE && (state == IDLE);
   assign md_stall = md_start || (state == MD_BUSY && md_cnt != '0);
   assign lw_stall = (state == IDLE) && hz.ResultSrcEb0 && (hz.RdE != '0) &&
                     (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
   // StallE is low whenever neither memWait nor an MD stall holds E
   assign br_fire  = hz.PCSrcE && !mem_wait && !md_stall;

   assign hz.ForwardAE = rst_n ? fwd_sel(hz.Rs1E) : 2'b00;
   assign hz.ForwardBE = rst_n ? fwd_sel(hz.Rs2E) : 2'b00;
   assign hz.MdBusy    = rst_n && (state == MD_BUSY);
   assign hz.MemErr    = rst_n && mem_err;

   always_comb begin
      hz.StallF = 1'b0;
      hz.StallD = 1'b0;
      hz.StallE = 1'b0;
      hz.StallM = 1'b0;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushM = 1'b0;
      hz.FlushW = 1'b0;
      if (!rst_n) begin
         hz.FlushD = 1'b1;
         hz.FlushE = 1'b1;
         hz.FlushM = 1'b1;
         hz.FlushW = 1'b1;
      end else if (mem_wait) begin
         hz.StallF = 1'b1;
         hz.StallD = 1'b1;
         hz.StallE = 1'b1;
         hz.StallM = 1'b1;
         hz.FlushW = 1'b1;
      end else if (md_stall) begin
         hz.StallF = 1'b1;
         hz.StallD = 1'b1;
         hz.StallE = 1'b1;
         hz.FlushM = 1'b1;
      end else begin
         hz.StallF = lw_stall;
         hz.StallD = lw_stall;
         hz.FlushD = br_fire;
         hz.FlushE = lw_stall | br_fire;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         md_cnt   <= '0;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         if (state == IDLE) begin
            if (md_start) begin
               md_cnt <= MD_CW'(MD_LATENCY - 2);
               state  <= MD_BUSY;
            end
         end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_CW'(1);
         end else if (!mem_wait) begin
            state <= IDLE;
         end
         // The error fires on the edge that completes the MEM_TIMEOUT-th wait cycle
         if (mem_wait) begin
            if (wait_cnt != WT_CW'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WT_CW'(1);
            if (wait_cnt >= WT_CW'(MEM_TIMEOUT - 1)) mem_err <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] perf_stall, perf_flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall <= '0;
         perf_flush <= '0;
      end else begin
         if (hz.StallF && perf_stall != '1) perf_stall <= perf_stall + CNT_W'(1);
         if (br_fire && perf_flush != '1)   perf_flush <= perf_flush + CNT_W'(1);
      end
   end

   assign hz.PerfStallCnt = rst_n ? perf_stall : '0;
   assign hz.PerfFlushCnt = rst_n ? perf_flush : '0;
`else
   assign hz.PerfStallCnt = '0;
   assign hz.PerfFlushCnt = '0;
`endif
endmodule
